operand_forward_unit: RTL and testbench

//  Operand-delivery stage between the 32x32 register file read ports (PA/PB) and the execute stage.

---
 rtl/operand_forward_unit.sv | 157 +++++++++++++++
 tb/tb_operand_forward_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_unit.sv
// Operand-delivery stage: forwards in-flight EX/MEM/WB results over stale register-file
// data, raises a one-cycle load-use stall and drives the register-file write controls.
module operand_forward_unit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ID_VALID,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    input  logic             ID_USE_A,
    input  logic             ID_USE_B,
    input  logic [DW-1:0]    PA,
    input  logic [DW-1:0]    PB,
    input  logic [AW-1:0]    ID_RW,
    input  logic             ID_LE,
    input  logic             ID_LOAD,
    input  logic             FLUSH,
    input  logic [DW-1:0]    EX_RES,
    input  logic [DW-1:0]    MEM_RES,
    input  logic [DW-1:0]    WB_RES,
    output logic [DW-1:0]    OA,
    output logic [DW-1:0]    OB,
    output logic             STALL,
    output logic [AW-1:0]    WB_RW,
    output logic             WB_LE,
    output logic [CNT_W-1:0] STALL_CNT
);

    // EX slot keeps its load flag; MEM/WB only need valid/rw/le.
    logic             ex_valid_r;
    logic [AW-1:0]    ex_rw_r;
    logic             ex_le_r;
    logic             ex_load_r;
    logic             mem_valid_r;
    logic [AW-1:0]    mem_rw_r;
    logic             mem_le_r;
    logic [AW-1:0]    wb_rw_r;
    logic             wb_le_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             stall_s;
    logic [DW-1:0]    oa_s;
    logic [DW-1:0]    ob_s;
    logic [2:0]       hit_a_s;
    logic [2:0]       hit_b_s;

    function automatic logic slot_writes(
        input logic          valid,
        input logic          le,
        input logic [AW-1:0] rw,
        input logic [AW-1:0] r
    );
        return valid & le & (rw == r) & (r != {AW{1'b0}});
    endfunction

    // Youngest match wins: EX over MEM over WB over register file.
    function automatic logic [DW-1:0] fwd_mux(
        input logic [2:0]    hit,
        input logic [DW-1:0] ex_res,
        input logic [DW-1:0] mem_res,
        input logic [DW-1:0] wb_res,
        input logic [DW-1:0] rf
    );
        logic [DW-1:0] sel;
        casez (hit)
            3'b1??:  sel = ex_res;
            3'b01?:  sel = mem_res;
            3'b001:  sel = wb_res;
            default: sel = rf;
        endcase
        return sel;
    endfunction

    // Per-slot match vectors; a load in EX has no result yet so it cannot forward.
    always_comb begin
        hit_a_s = {slot_writes(ex_valid_r, ex_le_r, ex_rw_r, RA) & ~ex_load_r,
                   slot_writes(mem_valid_r, mem_le_r, mem_rw_r, RA),
                   slot_writes(1'b1, wb_le_r, wb_rw_r, RA)};
        hit_b_s = {slot_writes(ex_valid_r, ex_le_r, ex_rw_r, RB) & ~ex_load_r,
                   slot_writes(mem_valid_r, mem_le_r, mem_rw_r, RB),
                   slot_writes(1'b1, wb_le_r, wb_rw_r, RB)};
    end

    // Operand selection with R0 forced to zero.
    always_comb begin
        oa_s = {DW{1'b0}};
        ob_s = {DW{1'b0}};
        if (RA == {AW{1'b0}}) begin
            oa_s = {DW{1'b0}};
        end else begin
            oa_s = fwd_mux(hit_a_s, EX_RES, MEM_RES, WB_RES, PA);
        end
        if (RB == {AW{1'b0}}) begin
            ob_s = {DW{1'b0}};
        end else begin
            ob_s = fwd_mux(hit_b_s, EX_RES, MEM_RES, WB_RES, PB);
        end
    end

    // Load-use hazard detection; a flushed decode never stalls.
    always_comb begin
        stall_s = 1'b0;
        if (ID_VALID && !FLUSH) begin
            stall_s = (ID_USE_A & slot_writes(ex_valid_r, ex_le_r, ex_rw_r, RA) & ex_load_r) |
                      (ID_USE_B & slot_writes(ex_valid_r, ex_le_r, ex_rw_r, RB) & ex_load_r);
        end else begin
            stall_s = 1'b0;
        end
    end

    // Scoreboard shift; stalled or flushed decode enters EX as a bubble.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_valid_r  <= 1'b0;
            ex_rw_r     <= {AW{1'b0}};
            ex_le_r     <= 1'b0;
            ex_load_r   <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_rw_r    <= {AW{1'b0}};
            mem_le_r    <= 1'b0;
            wb_rw_r     <= {AW{1'b0}};
            wb_le_r     <= 1'b0;
        end else begin
            ex_valid_r  <= ID_VALID & ~FLUSH & ~stall_s;
            ex_rw_r     <= ID_RW;
            ex_le_r     <= ID_LE;
            ex_load_r   <= ID_LOAD;
            mem_valid_r <= ex_valid_r;
            mem_rw_r    <= ex_rw_r;
            mem_le_r    <= ex_le_r;
            wb_rw_r     <= mem_rw_r;
            wb_le_r     <= mem_valid_r & mem_le_r & (mem_rw_r != {AW{1'b0}});
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign OA        = oa_s;
    assign OB        = ob_s;
    assign STALL     = stall_s;
    assign WB_RW     = wb_rw_r;
    assign WB_LE     = wb_le_r;
    assign STALL_CNT = stall_cnt_r;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed vector table, hand-written corner sequences
// and randomized traffic checked against an in-order instruction-list model.
module tb_operand_forward_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        ID_VALID, ID_USE_A, ID_USE_B, ID_LE, ID_LOAD, FLUSH;
    logic [4:0]  RA, RB, ID_RW;
    logic [31:0] PA, PB, EX_RES, MEM_RES, WB_RES;
    logic [31:0] OA, OB;
    logic        STALL, WB_LE;
    logic [4:0]  WB_RW;
    logic [15:0] STALL_CNT;

    operand_forward_unit #(.DW(32), .AW(5), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .ID_VALID(ID_VALID), .RA(RA), .RB(RB),
        .ID_USE_A(ID_USE_A), .ID_USE_B(ID_USE_B), .PA(PA), .PB(PB),
        .ID_RW(ID_RW), .ID_LE(ID_LE), .ID_LOAD(ID_LOAD), .FLUSH(FLUSH),
        .EX_RES(EX_RES), .MEM_RES(MEM_RES), .WB_RES(WB_RES),
        .OA(OA), .OB(OB), .STALL(STALL), .WB_RW(WB_RW), .WB_LE(WB_LE),
        .STALL_CNT(STALL_CNT)
    );

    always #5 Clk = ~Clk;

    // Model: list of in-flight instructions, index 0 youngest (EX) .. 2 oldest (WB).
    typedef struct { bit v; bit [4:0] rw; bit le; bit ld; } inst_t;
    inst_t pipe[3];
    int    m_cnt;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    typedef struct {
        bit v; bit [4:0] ra, rb; bit ua, ub; bit [31:0] pa, pb;
        bit [4:0] rw; bit le, ld, fl; bit [31:0] exr, memr, wbr;
        bit [31:0] eoa, eob; bit est, ewble; bit [4:0] ewbrw; bit [15:0] ecnt;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_load_hit(input bit [4:0] r);
        return pipe[0].v && pipe[0].le && pipe[0].ld && pipe[0].rw == r && r != 5'd0;
    endfunction

    function automatic bit [31:0] m_fwd(input bit [4:0] r, input bit [31:0] rf);
        bit [31:0] res[3];
        res[0] = EX_RES; res[1] = MEM_RES; res[2] = WB_RES;
        if (r == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++)
            if (pipe[i].v && pipe[i].le && pipe[i].rw == r && !(i == 0 && pipe[i].ld))
                return res[i];
        return rf;
    endfunction

    function automatic bit m_stall();
        if (!ID_VALID || FLUSH) return 1'b0;
        return (ID_USE_A && m_load_hit(RA)) || (ID_USE_B && m_load_hit(RB));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
        m_cnt = 0;
    endtask

    task automatic check_model(input string tag);
        if (ID_USE_A) chk({tag, "_OA"}, OA, m_fwd(RA, PA));
        if (ID_USE_B) chk({tag, "_OB"}, OB, m_fwd(RB, PB));
        chk({tag, "_STALL"}, 32'(STALL), 32'(m_stall()));
        chk({tag, "_WB_LE"}, 32'(WB_LE), 32'(pipe[2].v && pipe[2].le && pipe[2].rw != 5'd0));
        chk({tag, "_WB_RW"}, 32'(WB_RW), 32'(pipe[2].rw));
        chk({tag, "_CNT"}, 32'(STALL_CNT), 32'(m_cnt));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge.
    task automatic tick();
        bit st;
        st = m_stall();
        @(posedge Clk);
        if (st && m_cnt != 65535) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{ID_VALID && !FLUSH && !st, ID_RW, ID_LE, ID_LOAD};
        @(negedge Clk);
    endtask

    task automatic idle();
        ID_VALID = 1'b0; ID_USE_A = 1'b0; ID_USE_B = 1'b0; ID_LE = 1'b0;
        ID_LOAD = 1'b0; FLUSH = 1'b0; RA = 5'd0; RB = 5'd0; ID_RW = 5'd0;
        PA = 32'd0; PB = 32'd0; EX_RES = 32'd0; MEM_RES = 32'd0; WB_RES = 32'd0;
    endtask

    task automatic issue(input bit [4:0] rw, input bit le, input bit ld);
        idle();
        ID_VALID = 1'b1; ID_RW = rw; ID_LE = le; ID_LOAD = ld;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // v ra rb ua ub pa pb rw le ld fl exr memr wbr | eoa eob est ewble ewbrw ecnt
        tbl[0] = '{1, 1, 2, 1, 1, 32'h100, 32'h200, 5, 1, 0, 0, 0, 0, 0, 32'h100, 32'h200, 0, 0, 0, 0};
        tbl[1] = '{1, 5, 0, 1, 1, 32'h999, 32'h77, 6, 1, 0, 0, 32'h11, 0, 0, 32'h11, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 5, 6, 1, 1, 32'h999, 32'h3, 0, 0, 0, 0, 32'h22, 32'h11, 0, 32'h11, 32'h22, 0, 0, 0, 0};
        tbl[3] = '{0, 5, 6, 1, 1, 32'h999, 32'h3, 0, 0, 0, 0, 0, 32'h22, 32'h11, 32'h11, 32'h22, 0, 1, 5, 0};
        tbl[4] = '{1, 1, 2, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0};
        tbl[5] = '{1, 3, 7, 1, 1, 32'h33, 32'h44, 8, 1, 0, 0, 0, 0, 0, 32'h33, 32'h44, 1, 0, 0, 0};
        tbl[6] = '{1, 3, 7, 1, 1, 32'h33, 32'h44, 8, 1, 0, 0, 0, 32'hDEADBEEF, 0, 32'h33, 32'hDEADBEEF, 0, 0, 0, 1};
        tbl[7] = '{0, 0, 8, 1, 1, 32'h55, 32'h1, 0, 0, 0, 0, 32'h88, 0, 0, 0, 32'h88, 0, 1, 7, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1};

        idle();
        m_reset();
        repeat (2) @(negedge Clk);
        RA = 5'd4; ID_USE_A = 1'b1; PA = 32'h1234; RB = 5'd0; ID_USE_B = 1'b1; PB = 32'h99;
        #1;
        chk("rst_OA", OA, 32'h1234);
        chk("rst_OB_r0", OB, 32'd0);
        chk("rst_WB_LE", 32'(WB_LE), 32'd0);
        chk("rst_CNT", 32'(STALL_CNT), 32'd0);
        chk("rst_STALL", 32'(STALL), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Directed table: ALU chain then load-use.
        for (int i = 0; i < 9; i++) begin
            ID_VALID = tbl[i].v; RA = tbl[i].ra; RB = tbl[i].rb;
            ID_USE_A = tbl[i].ua; ID_USE_B = tbl[i].ub; PA = tbl[i].pa; PB = tbl[i].pb;
            ID_RW = tbl[i].rw; ID_LE = tbl[i].le; ID_LOAD = tbl[i].ld; FLUSH = tbl[i].fl;
            EX_RES = tbl[i].exr; MEM_RES = tbl[i].memr; WB_RES = tbl[i].wbr;
            #1;
            if (tbl[i].ua) chk($sformatf("tbl%0d_OA", i), OA, tbl[i].eoa);
            if (tbl[i].ub) chk($sformatf("tbl%0d_OB", i), OB, tbl[i].eob);
            chk($sformatf("tbl%0d_STALL", i), 32'(STALL), 32'(tbl[i].est));
            chk($sformatf("tbl%0d_WB_LE", i), 32'(WB_LE), 32'(tbl[i].ewble));
            chk($sformatf("tbl%0d_WB_RW", i), 32'(WB_RW), 32'(tbl[i].ewbrw));
            chk($sformatf("tbl%0d_CNT", i), 32'(STALL_CNT), 32'(tbl[i].ecnt));
            tick();
        end

        // Priority: r3 in EX, MEM and WB, then aging out one slot at a time.
        for (int i = 0; i < 3; i++) begin
            issue(5'd3, 1'b1, 1'b0);
            #1 check_model("prio_fill");
            tick();
        end
        idle();
        RA = 5'd3; ID_USE_A = 1'b1;
        EX_RES = 32'hA; MEM_RES = 32'hB; WB_RES = 32'hC; PA = 32'hD;
        #1 chk("prio_ex", OA, 32'hA);
        tick();
        #1 chk("prio_mem", OA, 32'hB);
        tick();
        #1 chk("prio_wb", OA, 32'hC);
        tick();
        #1 chk("prio_none", OA, 32'hD);
        tick();

        // R0: write to r0 never enables the register file, never forwards, never stalls.
        issue(5'd0, 1'b1, 1'b0);
        tick();
        idle(); tick(); tick();
        #1 chk("r0_WB_LE", 32'(WB_LE), 32'd0);
        issue(5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd2, 1'b1, 1'b0);
        RA = 5'd0; ID_USE_A = 1'b1; PA = 32'h55;
        #1;
        chk("r0_OA", OA, 32'd0);
        chk("r0_STALL", 32'(STALL), 32'd0);
        tick();

        // FLUSH beats a pending load-use; unused source never stalls.
        issue(5'd7, 1'b1, 1'b1);
        tick();
        issue(5'd9, 1'b1, 1'b0);
        RB = 5'd7; ID_USE_B = 1'b1; FLUSH = 1'b1;
        #1 chk("flush_STALL", 32'(STALL), 32'd0);
        tick();
        idle(); tick(); tick();
        #1;
        chk("flush_WB_LE", 32'(WB_LE), 32'd0);
        check_model("flush");
        issue(5'd9, 1'b1, 1'b1);
        tick();
        issue(5'd10, 1'b1, 1'b0);
        RA = 5'd9; ID_USE_A = 1'b0;
        #1 chk("usea0_STALL", 32'(STALL), 32'd0);
        tick();

        // Async reset between edges with a live WB write in flight.
        for (int i = 0; i < 3; i++) begin
            issue(5'd4, 1'b1, 1'b0);
            tick();
        end
        idle();
        #1 chk("pre_rst_WB_LE", 32'(WB_LE), 32'd1);
        Rst = 1'b1;
        #1;
        chk("mid_rst_WB_LE", 32'(WB_LE), 32'd0);
        chk("mid_rst_CNT", 32'(STALL_CNT), 32'd0);
        m_reset();
        Rst = 1'b0;
        RA = 5'd4; ID_USE_A = 1'b1; PA = 32'h77; EX_RES = 32'h1; MEM_RES = 32'h2; WB_RES = 32'h3;
        #1 chk("post_rst_OA", OA, 32'h77);
        tick();

        // Randomized traffic against the model, small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            ID_VALID = ($urandom_range(0, 9) < 8);
            RA = 5'($urandom_range(0, 3));
            RB = 5'($urandom_range(0, 3));
            ID_USE_A = 1'($urandom);
            ID_USE_B = 1'($urandom);
            ID_RW = 5'($urandom_range(0, 3));
            ID_LE = ($urandom_range(0, 3) != 0);
            ID_LOAD = ($urandom_range(0, 9) < 3);
            FLUSH = ($urandom_range(0, 9) == 0);
            PA = $urandom; PB = $urandom;
            EX_RES = $urandom; MEM_RES = $urandom; WB_RES = $urandom;
            #1 check_model("rand");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
